uart_tx_frame: RTL

//  UART transmitter for the low-power link; counterpart of the Uart_Rx path.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_serializer.sv | 54 +++++
 rtl/uart_tx_frame.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, line levels and parity helper.
// Used by both the TX and RX paths so framing conventions stay in lockstep.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // xor_all is the reduction XOR of the data word.
    function automatic logic parity_bit(input logic xor_all, input logic ptype);
        return (ptype == PARITY_ODD) ? ~xor_all : xor_all;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Load-enabled LSB-first shift register plus data-bit counter for the TX FSM.
// serial_bit_o is always the next data bit to be put on the line.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  shift_i,
    input  logic                  count_i,
    input  logic                  clear_i,
    output logic                  serial_bit_o,
    output logic                  last_bit_o
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        if (load_i) begin
            shift_d = data_i;
        end else if (shift_i) begin
            shift_d = shift_q >> 1;
        end
    end

    // The counter never wraps on its own; the FSM clears it when leaving DATA.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign serial_bit_o = shift_q[0];
    assign last_bit_o   = (cnt_q == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start / DATA_WIDTH data bits LSB first / optional parity / stop,
// one bit per CLK. TX_OUT and Busy come straight from flops.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  Data_Valid,
    input  logic                  Parity_EN,
    input  logic                  Parity_type,
    output logic                  TX_OUT,
    output logic                  Busy
);

    logic [2:0] state_q, state_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       par_en_q, par_en_d;
    logic       par_bit_q, par_bit_d;

    logic load, shift, count, clear;
    logic serial_bit, last_bit;

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk_i        (CLK),
        .rst_i        (Reset),
        .load_i       (load),
        .data_i       (P_Data),
        .shift_i      (shift),
        .count_i      (count),
        .clear_i      (clear),
        .serial_bit_o (serial_bit),
        .last_bit_o   (last_bit)
    );

    // Each state names the bit currently on the line; tx_d is the bit for the next cycle.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        load      = 1'b0;
        shift     = 1'b0;
        count     = 1'b0;
        clear     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = STOP_BIT;
                busy_d = 1'b0;
                if (Data_Valid) begin
                    load      = 1'b1;
                    clear     = 1'b1;
                    par_en_d  = Parity_EN;
                    par_bit_d = parity_bit(^P_Data, Parity_type);
                    tx_d      = START_BIT;
                    busy_d    = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                tx_d    = serial_bit;
                shift   = 1'b1;
                state_d = DATA;
            end
            DATA: begin
                if (last_bit) begin
                    clear = 1'b1;
                    if (par_en_q) begin
                        tx_d    = par_bit_q;
                        state_d = PARITY;
                    end else begin
                        tx_d    = STOP_BIT;
                        state_d = STOP;
                    end
                end else begin
                    tx_d  = serial_bit;
                    shift = 1'b1;
                    count = 1'b1;
                end
            end
            PARITY: begin
                tx_d    = STOP_BIT;
                state_d = STOP;
            end
            STOP: begin
                tx_d    = STOP_BIT;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                tx_d    = STOP_BIT;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            tx_q      <= STOP_BIT;
            busy_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule
